// File: rtl/audio_i2s_tx.sv
// ---------------------------------------------------------------------------
// audio_i2s_tx
//
// Philips I2S transmitter running directly on the audio PLL clock. A stereo
// PCM pair is accepted over valid/ready into a one-deep holding register and
// is moved into the 64-bit frame register at the start of each frame. Each
// channel is left-justified in a 32-bit slot, MSB first, delayed by one SCLK
// after the LRCLK edge. With no new sample at frame start the previous frame
// is replayed and an underrun pulse is raised.
//
// Parameters
//   DW        sample width per channel, 1..32
//   SCLK_DIV  clk cycles per SCLK period, even and >= 2
//
// Ports
//   clk          audio clock
//   rst          synchronous reset, active-high
//   pll_locked   PLL lock status; low holds the block idle like rst
//   in_valid     sample pair offered
//   in_ready     holding register empty and block running
//   in_left      left sample, two's complement
//   in_right     right sample, two's complement
//   sclk         I2S bit clock
//   lrclk        word select, 0 = left slot, 1 = right slot
//   sdata        serial data, changes only while sclk is low
//   frame_start  one-cycle pulse in the frame load cycle
//   underrun     one-cycle pulse when a frame starts without a new sample
// ---------------------------------------------------------------------------
module audio_i2s_tx #(
   parameter int DW       = 16,
   parameter int SCLK_DIV = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pll_locked,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_left,
   input  logic [DW-1:0] in_right,
   output logic          sclk,
   output logic          lrclk,
   output logic          sdata,
   output logic          frame_start,
   output logic          underrun
);

   localparam int DIV_W = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);

   logic             run;
   logic             load;
   logic             accept;
   logic             div_wrap;

   logic [DIV_W-1:0] div_q, div_d;
   logic [5:0]       bit_q, bit_d;
   logic             hold_full_q, hold_full_d;
   logic [DW-1:0]    hold_l_q, hold_l_d;
   logic [DW-1:0]    hold_r_q, hold_r_d;
   // The frame register is never shifted, so after every load it also holds
   // the last transmitted sample pair; an underrun simply leaves it alone.
   logic [63:0]      frame_q, frame_d;
   logic             sdata_q, sdata_d;

   // Left-justify a sample inside its 32-bit slot.
   function automatic logic [31:0] to_slot(input logic [DW-1:0] s);
      return 32'(s) << (32 - DW);
   endfunction

   assign run      = ~rst & pll_locked;
   assign div_wrap = (div_q == DIV_LAST);
   assign load     = run && (div_q == '0) && (bit_q == '0);
   assign accept   = in_valid & in_ready;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves one unassigned and no latch is inferred.
      div_d       = div_q;
      bit_d       = bit_q;
      hold_full_d = hold_full_q;
      hold_l_d    = hold_l_q;
      hold_r_d    = hold_r_q;
      frame_d     = frame_q;
      sdata_d     = sdata_q;

      if (div_wrap) begin
         div_d = '0;
         bit_d = bit_q + 6'd1;
         // Slot bit n+1 carries F[63-n]; at bit 63 this picks F[0], which is
         // the one-SCLK-delayed last bit shown during the next frame's bit 0.
         sdata_d = frame_q[~bit_q];
      end else begin
         div_d = div_q + 1'b1;
      end

      // accept and a full-register load are mutually exclusive because
      // in_ready is low while hold_full is set.
      if (accept) begin
         hold_l_d    = in_left;
         hold_r_d    = in_right;
         hold_full_d = 1'b1;
      end

      if (load && hold_full_q) begin
         frame_d     = {to_slot(hold_l_q), to_slot(hold_r_q)};
         hold_full_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (rst || !pll_locked) begin
         // All state, data registers included, clears so a relock starts a
         // fresh frame of zeros rather than replaying stale audio.
         div_q       <= '0;
         bit_q       <= '0;
         hold_full_q <= 1'b0;
         hold_l_q    <= '0;
         hold_r_q    <= '0;
         frame_q     <= '0;
         sdata_q     <= 1'b0;
      end else begin
         div_q       <= div_d;
         bit_q       <= bit_d;
         hold_full_q <= hold_full_d;
         hold_l_q    <= hold_l_d;
         hold_r_q    <= hold_r_d;
         frame_q     <= frame_d;
         sdata_q     <= sdata_d;
      end
   end

   // Gating with run forces the line outputs low in the very cycle the
   // block is stopped, before the registers have cleared.
   assign sclk        = run & (div_q >= DIV_HALF);
   assign lrclk       = run & bit_q[5];
   assign sdata       = run & sdata_q;
   assign in_ready    = run & ~hold_full_q;
   assign frame_start = load;
   assign underrun    = load & ~hold_full_q;

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

I2S serial transmitter clocked directly by the 24.576 MHz audio PLL output. It accepts stereo PCM samples over a valid/ready handshake and holds them in a one-deep buffer. It serialises them as standard Philips I2S at 48 kHz (64 SCLK per frame, 32-bit slots) with derived SCLK and LRCLK. Output is held idle until the PLL reports lock.

## Interface
- DW, 16: sample width per channel; 1..32, MSB-first, left-justified in its 32-bit slot.
- SCLK_DIV, 8: clk cycles per SCLK period; even, ≥2 (8 → 3.072 MHz SCLK, 48 kHz LRCLK at 24.576 MHz).

- clk  in  1  audio clock (PLL output_0, 24.576 MHz).
- rst  in  1  synchronous reset, active-high.
- pll_locked  in  1  PLL lock status, synchronous to clk; 0 acts as reset.
- in_valid  in  1  sample pair offered.
- in_ready  out  1  holding register empty and block running.
- in_left  in  DW  left sample, two's complement.
- in_right  in  DW  right sample, two's complement.
- sclk  out  1  I2S bit clock.
- lrclk  out  1  word select; 0 = left slot, 1 = right slot.
- sdata  out  1  serial data, changes only while sclk low.
- frame_start  out  1  one-cycle pulse at the start of each frame.
- underrun  out  1  one-cycle pulse when a frame starts with no new sample.

## Operation
- run = ~rst & pll_locked, sampled each cycle. While run=0 the block is in idle:
  - div_cnt, bit_cnt, hold_full, and the hold and frame registers clear to 0.
  - Last-sample registers clear to 0.
  - sclk, lrclk, sdata, in_ready, frame_start and underrun are all 0.
- Dropping pll_locked or asserting rst mid-frame aborts the frame immediately. There is no drain.
- div_cnt counts 0..SCLK_DIV-1 and wraps. bit_cnt (6 bits) advances on every div_cnt wrap and wraps 63→0.
- Registered outputs: sclk = (div_cnt ≥ SCLK_DIV/2); lrclk = bit_cnt[5].
- Frame word F (64 bits) = {L, (32-DW) zeros, R, (32-DW) zeros}. F[63] is transmitted first.
- sdata in slot bit n: n=0 carries the last bit of the previous frame (F_prev[0]). n≥1 carries F[64-n]. This is the one-SCLK I2S delay after each LRCLK edge.
- Frame load happens at div_cnt=0 and bit_cnt=0, including the first cycle after run rises:
  - hold_full=1: F ← {hold_l, hold_r}, hold_full ← 0, and these become the last sample.
  - hold_full=0: F ← last sample (repeat), and underrun pulses.
- Handshake:
  - in_ready = run & ~hold_full (combinational).
  - in_valid & in_ready captures in_left/in_right and sets hold_full.
  - Frame load and accept never coincide, because in_ready=0 while hold_full=1.
  - A sample accepted on the load cycle itself is not full yet, so it waits for the next frame.
  - Offered data is not required to be held stable after acceptance.

## Timing
- Reset value of every output is 0.
- First cycle with run=1: div_cnt=0, bit_cnt=0, frame_start=1, sclk=0, lrclk=0, sdata=0 (F_prev = 0).
- Frame period = 64·SCLK_DIV clk cycles (512 at default). LRCLK is low for 32·SCLK_DIV cycles, then high for the same.
- sclk low for cycles div_cnt 0..SCLK_DIV/2-1, high for the rest. sdata and lrclk update only at div_cnt=0.
- The receiver samples on the sclk rising edge, SCLK_DIV/2 cycles after the data change.
- Latency from accept to MSB on sdata:
  - Up to one frame for the load.
  - Then SCLK_DIV cycles, because the MSB appears at slot bit 1.
- frame_start and underrun are asserted in the load cycle only.

## Test plan
- Reset/lock:
  - Hold rst=1 with pll_locked=1 → all outputs 0.
  - Release rst with pll_locked=0 → still idle.
  - Raise pll_locked → frame_start=1 on that cycle and underrun=1 (no sample yet); sclk toggles every 4 cycles.
- Single frame, DW=16:
  - Accept L=16'hA5C3, R=16'h0F0F before the load.
  - Sampling sdata on sclk rising edges gives: slot bits 1–16 = A5C3 MSB-first, bits 17–32 = 0, bits 33–48 = 0F0F, bits 49–63 = 0.
  - Next frame bit 0 = 0.
- Periods: lrclk rise-to-rise = 512 cycles with 256 low; frame_start spacing = 512 cycles.
- Backpressure and underrun:
  - Hold in_valid=1 continuously → in_ready drops after accept and re-asserts one cycle after each load; one sample is consumed per frame.
  - Stop supplying samples → next frame repeats the last L/R with underrun=1.
- Abort: deassert pll_locked at bit_cnt=20 → next cycle all outputs 0 and in_ready=0. Relock → a fresh frame from bit 0 with zeros.
- Parameters: DW=24, SCLK_DIV=4 → L=24'h800001 appears in slot bits 1–24; frame = 256 cycles.
